// File: rtl/fastica_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fastica_pkg
//  Description : Shared Q-format widths, unit constant and checker state
//                encoding for the FastICA convergence datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package fastica_pkg;

    // Q11.20 fixed-point format used by the normaliser and the checker
    localparam int Q_DIM = 5;
    localparam int Q_DW  = 32;
    localparam int Q_FW  = 20;
    localparam int Q_AW  = 36;

    // 1.0 in Q11.20
    localparam logic [31:0] ONE_Q20 = 32'h0010_0000;

    // Convergence checker state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fx_mac_q.sv
`default_nettype none
// ============================================================================
//  Module      : fx_mac_q
//  Description : Fixed-point serial MAC. Registered full-width signed
//                product, arithmetic right shift by FW, accumulate into a
//                signed AW-bit register. clr restarts the accumulation.
//  Revision    : 1.0  initial release
// ============================================================================
module fx_mac_q #(
    parameter int DW = 32,
    parameter int FW = 20,
    parameter int AW = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DW-1:0]        a,
    input  logic [DW-1:0]        b,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [2*DW-1:0] w_shift;
    logic signed [AW-1:0]   w_term;
    logic                   w_unused_hi;

    logic signed [2*DW-1:0] r_prod;
    logic                   r_pv;
    logic signed [AW-1:0]   r_acc;

    assign w_prod      = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    assign w_shift     = r_prod >>> FW;
    assign w_term      = w_shift[AW-1:0];
    assign w_unused_hi = ^w_shift[2*DW-1:AW];
    assign acc         = r_acc;

    // Product stage feeds the accumulator one cycle later
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_pv <= en;
            if (en) begin
                r_prod <= w_prod;
            end
            if (r_pv) begin
                r_acc <= r_acc + w_term;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_check_5d.sv
`default_nettype none
// ============================================================================
//  Module      : conv_check_5d
//  Description : FastICA convergence checker. Serially forms w_new.w_prev in
//                Q11.20 and flags convergence when |1 - |dot|| <= EPS.
//                Counts iterations and raises timeout at MAX_ITER.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_check_5d
    import fastica_pkg::*;
#(
    parameter int                 DIMENSIONS = Q_DIM,
    parameter int                 DATA_WIDTH = Q_DW,
    parameter int                 FRAC_WIDTH = Q_FW,
    parameter int                 ACC_WIDTH  = Q_AW,
    parameter logic [Q_DW-1:0]    EPS        = 32'h0000_0400,
    parameter int                 MAX_ITER   = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 w_new_vld,
    input  logic [DIMENSIONS*DATA_WIDTH-1:0]     w_new,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 converged,
    output logic                                 timeout,
    output logic [DATA_WIDTH-1:0]                dot_out,
    output logic [$clog2(MAX_ITER+1)-1:0]        iter_count,
    output logic [DIMENSIONS*DATA_WIDTH-1:0]     w_final
);

    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int IDX_W  = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

    localparam logic [ITER_W-1:0]           C_ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic [IDX_W-1:0]            C_IDX_LAST = IDX_W'(DIMENSIONS - 1);
    localparam logic signed [ACC_WIDTH-1:0] C_ONE      = ACC_WIDTH'($signed(ONE_Q20));
    localparam logic signed [ACC_WIDTH-1:0] C_EPS      = ACC_WIDTH'(EPS);
    localparam logic signed [ACC_WIDTH-1:0] C_DW_MAX   = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] C_DW_MIN   = -C_DW_MAX - 1;

    logic [1:0]                          r_state;
    logic [IDX_W-1:0]                    r_idx;
    logic [DIMENSIONS*DATA_WIDTH-1:0]    r_cur;
    logic [DIMENSIONS*DATA_WIDTH-1:0]    r_prev;
    logic [DIMENSIONS*DATA_WIDTH-1:0]    r_final;
    logic                                r_has_prev;
    logic                                r_ready;
    logic                                r_done;
    logic                                r_conv;
    logic                                r_tmo;
    logic [DATA_WIDTH-1:0]               r_dot;
    logic [ITER_W-1:0]                   r_iter;

    logic                                w_accept;
    logic                                w_mac_en;
    logic                                w_mac_clr;
    logic [DATA_WIDTH-1:0]               w_a;
    logic [DATA_WIDTH-1:0]               w_b;
    logic signed [ACC_WIDTH-1:0]         w_acc;
    logic signed [ACC_WIDTH-1:0]         w_mag;
    logic signed [ACC_WIDTH-1:0]         w_delta;
    logic signed [ACC_WIDTH-1:0]         w_diff;
    logic                                w_conv;
    logic                                w_verdict;
    logic [DATA_WIDTH-1:0]               w_sat;

    // A new vector is taken only while idle; clear wins over a same-cycle accept
    assign w_accept  = r_ready & w_new_vld & ~clear;
    assign w_mac_en  = (r_state == MAC);
    assign w_mac_clr = clear | w_accept;
    assign w_a       = r_cur[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_b       = r_prev[r_idx*DATA_WIDTH +: DATA_WIDTH];

    fx_mac_q #(
        .DW (DATA_WIDTH),
        .FW (FRAC_WIDTH),
        .AW (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (w_mac_clr),
        .en    (w_mac_en),
        .a     (w_a),
        .b     (w_b),
        .acc   (w_acc)
    );

    // Distance of |dot| from unity and saturation of the dot product
    always_comb begin
        w_mag   = w_acc[ACC_WIDTH-1] ? -w_acc : w_acc;
        w_delta = C_ONE - w_mag;
        w_diff  = w_delta[ACC_WIDTH-1] ? -w_delta : w_delta;
        w_conv  = (w_diff <= C_EPS);
        if (w_acc > C_DW_MAX) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_acc < C_DW_MIN) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            w_sat = w_acc[DATA_WIDTH-1:0];
        end
    end

    // The first vector after clear has nothing to compare against
    assign w_verdict = r_has_prev & w_conv;

    // Control FSM, vector registers and result registers. The accumulator
    // settles during CMP (product pipeline drain) and is judged in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cur      <= '0;
            r_prev     <= '0;
            r_final    <= '0;
            r_has_prev <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_tmo      <= 1'b0;
            r_dot      <= '0;
            r_iter     <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_has_prev <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_tmo      <= 1'b0;
            r_iter     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_cur   <= w_new;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        if (r_iter != C_ITER_MAX) begin
                            r_iter <= r_iter + 1'b1;
                        end
                        r_state <= r_has_prev ? MAC : DONE;
                    end
                end
                MAC: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_IDX_LAST) begin
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_conv     <= w_verdict;
                    r_tmo      <= ~w_verdict & (r_iter == C_ITER_MAX);
                    r_dot      <= r_has_prev ? w_sat : '0;
                    r_final    <= r_cur;
                    r_prev     <= r_cur;
                    r_has_prev <= 1'b1;
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign converged  = r_conv;
    assign timeout    = r_tmo;
    assign dot_out    = r_dot;
    assign iter_count = r_iter;
    assign w_final    = r_final;

endmodule
`default_nettype wire

// File: tb/tb_conv_check_5d.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_check_5d
//  Description : Scoreboard bench for conv_check_5d. Expected results come
//                from a plain-arithmetic dot-product model; a monitor checks
//                every done pulse against the queued expectation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_check_5d;

    localparam int DIM  = 5;
    localparam int DW   = 32;
    localparam int MAXI = 3;
    localparam int IW   = $clog2(MAXI + 1);
    localparam int VW   = DIM * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          w_new_vld;
    logic [VW-1:0] w_new;
    logic          ready;
    logic          done;
    logic          converged;
    logic          timeout;
    logic [DW-1:0] dot_out;
    logic [IW-1:0] iter_count;
    logic [VW-1:0] w_final;

    conv_check_5d #(
        .MAX_ITER (MAXI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .w_new_vld  (w_new_vld),
        .w_new      (w_new),
        .ready      (ready),
        .done       (done),
        .converged  (converged),
        .timeout    (timeout),
        .dot_out    (dot_out),
        .iter_count (iter_count),
        .w_final    (w_final)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   when;
        logic          conv;
        logic          tmo;
        logic [DW-1:0] dot;
        logic [IW-1:0] iter;
        logic [VW-1:0] wf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic          m_has_prev = 1'b0;
    logic [VW-1:0] m_prev     = '0;
    int            m_iter     = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Model: dot = sum(floor(a*b / 2^20)), verdict |1.0 - |dot|| <= 1024
    task automatic model_push(input logic [VW-1:0] v, input int unsigned accept_cyc);
        exp_t   e;
        longint acc, a, b, mag, diff;
        acc = 0;
        for (int i = 0; i < DIM; i++) begin
            a = longint'($signed(v[i*DW +: DW]));
            b = longint'($signed(m_prev[i*DW +: DW]));
            acc += (a * b) >>> 20;
        end
        if (m_has_prev) begin
            mag    = (acc < 0) ? -acc : acc;
            diff   = 64'sd1048576 - mag;
            diff   = (diff < 0) ? -diff : diff;
            e.conv = (diff <= 1024);
            if (acc > 64'sd2147483647)       e.dot = 32'h7FFF_FFFF;
            else if (acc < -64'sd2147483648) e.dot = 32'h8000_0000;
            else                             e.dot = acc[DW-1:0];
            e.when = accept_cyc + 7;
        end else begin
            e.conv = 1'b0;
            e.dot  = '0;
            e.when = accept_cyc + 1;
        end
        m_iter     = (m_iter < MAXI) ? m_iter + 1 : MAXI;
        e.iter     = IW'(m_iter);
        e.tmo      = !e.conv && (m_iter == MAXI);
        e.wf       = v;
        m_prev     = v;
        m_has_prev = 1'b1;
        q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", VW'(cyc),        VW'(e.when));
                    chk("converged",  VW'(converged),  VW'(e.conv));
                    chk("timeout",    VW'(timeout),    VW'(e.tmo));
                    chk("dot_out",    VW'(dot_out),    VW'(e.dot));
                    chk("iter_count", VW'(iter_count), VW'(e.iter));
                    chk("w_final",    w_final,         e.wf);
                    chk("ready_at_done", VW'(ready),   VW'(1'b1));
                end
            end
        end
    end

    function automatic logic [VW-1:0] unit_vec(input int k, input logic [DW-1:0] val);
        logic [VW-1:0] v;
        v = '0;
        v[k*DW +: DW] = val;
        return v;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (ready !== 1'b1) fail_now("ready_wait_expired");
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (q.size() != 0) fail_now("drain_wait_expired");
        @(posedge clk); #1;
    endtask

    // Issue one vector; optionally pulse w_new_vld during MAC/CMP (must be ignored)
    task automatic send(input logic [VW-1:0] v, input bit noise);
        bit busy;
        wait_ready();
        busy      = m_has_prev;
        w_new     = v;
        w_new_vld = 1'b1;
        model_push(v, cyc + 1);
        @(posedge clk); #1;
        w_new_vld = 1'b0;
        if (noise && busy) begin
            for (int k = 0; k < 6; k++) begin
                w_new     = {$urandom, $urandom, $urandom, $urandom, $urandom};
                w_new_vld = k[0];
                @(posedge clk); #1;
            end
            w_new_vld = 1'b0;
        end
    endtask

    task automatic do_clear();
        wait_drain();
        clear = 1'b1;
        @(posedge clk); #1;
        clear      = 1'b0;
        m_has_prev = 1'b0;
        m_iter     = 0;
    endtask

    function automatic logic [DW-1:0] rnd_elem();
        return DW'($urandom_range(0, 2097152)) - 32'h0010_0000;
    endfunction

    logic [VW-1:0] v_r;
    logic [VW-1:0] e1, e2, e3;

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        w_new_vld = 1'b0;
        w_new     = '0;
        e1 = unit_vec(0, 32'h0010_0000);
        e2 = unit_vec(1, 32'h0010_0000);
        e3 = unit_vec(2, 32'h0010_0000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ready",     VW'(ready),      VW'(1'b1));
        chk("rst_done",      VW'(done),       VW'(1'b0));
        chk("rst_converged", VW'(converged),  VW'(1'b0));
        chk("rst_timeout",   VW'(timeout),    VW'(1'b0));
        chk("rst_dot",       VW'(dot_out),    VW'(0));
        chk("rst_iter",      VW'(iter_count), VW'(0));
        chk("rst_w_final",   w_final,         VW'(0));

        // First vector, repeat, sign flip (iteration limit reached while converged)
        send(e1, 1'b0);
        send(e1, 1'b1);
        send(~e1 + 1'b1 & unit_vec(0, 32'hFFFF_FFFF), 1'b0);

        // Orthogonal vectors up to the iteration limit
        do_clear();
        send(e1, 1'b0);
        send(e2, 1'b0);
        send(e3, 1'b0);

        // Clear in the middle of MAC
        do_clear();
        send(e1, 1'b0);
        wait_drain();
        wait_ready();
        w_new     = e1;
        w_new_vld = 1'b1;
        @(posedge clk); #1;
        w_new_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear      = 1'b0;
        m_has_prev = 1'b0;
        m_iter     = 0;
        chk("clr_ready",     VW'(ready),      VW'(1'b1));
        chk("clr_iter",      VW'(iter_count), VW'(0));
        chk("clr_converged", VW'(converged),  VW'(1'b0));
        repeat (10) @(posedge clk);
        #1;
        send(e1, 1'b0);

        // Near-unit tolerance edges and a zero vector
        send(unit_vec(0, 32'h000F_FC00), 1'b1);
        do_clear();
        send(e1, 1'b0);
        send(unit_vec(0, 32'h000F_FBFF), 1'b0);
        send('0, 1'b0);
        send(e2, 1'b0);

        // Randomized sequences
        for (int n = 0; n < 40; n++) begin
            if ((n % 6) == 0) do_clear();
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < DIM; i++) v_r[i*DW +: DW] = rnd_elem();
                end
                1: begin
                    v_r = m_prev;
                    v_r[0 +: DW] = v_r[0 +: DW] + DW'($urandom_range(0, 4000)) - 32'd2000;
                end
                2: begin
                    for (int i = 0; i < DIM; i++) v_r[i*DW +: DW] = -m_prev[i*DW +: DW];
                end
                default: begin
                    v_r = unit_vec(int'($urandom_range(0, DIM - 1)),
                                   ($urandom_range(0, 1) != 0) ? 32'h0010_0000 : 32'hFFF0_0000);
                end
            endcase
            send(v_r, $urandom_range(0, 1) != 0);
        end

        wait_drain();
        chk("queue_empty", VW'(q.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
